time_decoder: RTL and testbench
===============================

TIME_DECODER -- requirements
Module: time_decoder

Interface
REQ-001 Parameter UNIT_CYCLES, default 8: clk cycles per encoder time unit; legal values are 2..64 and even.
REQ-002 Parameter WINDOW_UNITS, default 5: time units from start to the no-pulse timeout; legal values are 4..15.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  frame strobe, clk-synchronous; the same signal that triggers the encoder; only its rising edge is used.
REQ-007 tin  input  1  time-encoded pulse; high width = symbol x UNIT_CYCLES.
REQ-008 dout  output  2  decoded symbol 0..3.
REQ-009 valid  output  1  one-cycle strobe; dout/err are new in that cycle.
REQ-010 err  output  1  the symbol is a glitch or over-length pulse; qualified by valid.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 Edge detect: start_rise = start & ~start_q, where start_q is a registered copy of start.
REQ-013 tin_s is the conditioned tin (see Configuration); all measurement uses tin_s.
REQ-014 The FSM SHALL have 4 states: IDLE, ARMED, MEASURE, DONE.
REQ-015 IDLE -> ARMED on start_rise; this transition clears win_cnt and wid_cnt.
REQ-016 start_rise outside IDLE SHALL be ignored; it causes no restart and no error.
REQ-017 ARMED: win_cnt increments each cycle.
- tin_s=1 moves the FSM to MEASURE with wid_cnt=1.
- win_cnt = WINDOW_UNITS*UNIT_CYCLES-1 with tin_s=0 moves the FSM to DONE with code 0, err=0.
REQ-018 MEASURE: wid_cnt increments each cycle while tin_s=1.
- tin_s=0 moves the FSM to DONE.
- wid_cnt reaching 4*UNIT_CYCLES moves the FSM to DONE with err=1 and dout=3, without waiting for the fall.
REQ-019 Decode rule: code = floor((wid_cnt + UNIT_CYCLES/2) / UNIT_CYCLES).
- code 0 (pulse shorter than UNIT_CYCLES/2): dout=0, err=1 (glitch).
- code 4 or more: dout=3, err=1.
- code 1..3: dout=code, err=0.
REQ-020 Width rule: counters SHALL be wide enough for WINDOW_UNITS*UNIT_CYCLES with no wrap-around; wid_cnt saturates.
REQ-021 DONE lasts exactly one cycle; valid=1 in it; next state is IDLE.
REQ-022 dout and err SHALL hold their values until the next valid.
REQ-023 Latency: valid rises exactly 1 cycle after the first cycle with tin_s=0 in MEASURE.
REQ-024 A pulse already high at start_rise is measured from ARMED entry, not from its true rise.
REQ-025 When tin_s=1 arrives in the same cycle as the window expiry, MEASURE takes priority over the timeout.

Reset
REQ-026 While rst_n=0 the block SHALL hold state=IDLE and all counters=0; it also holds:
- dout=0, valid=0, err=0, busy=0;
- start_q=0 and synchronizer flops=0.
REQ-027 Reset mid-MEASURE SHALL discard the symbol; after release, valid SHALL NOT assert until a new start_rise and a completed decode.
REQ-028 Reset release is assumed synchronous to clk by the integrator; no internal reset synchronizer.

Configuration
REQ-029 Macro TIME_DECODER_SYNC_EN.
- Defined: tin passes through a 2-flop synchronizer before use as tin_s; latency from the tin pin grows by 2 cycles; window timing is unchanged.
- Undefined: tin_s = tin sampled directly, for same-clock-domain benches only.

Verification (UNIT_CYCLES=8, WINDOW_UNITS=5, macro undefined)
REQ-030 start rise, then tin high 16 cycles -> valid one cycle after the fall, dout=2, err=0.
REQ-031 start rise, no tin for 40 cycles -> valid at window end, dout=0, err=0, then busy=0.
REQ-032 tin widths 3, 12 and 28 -> dout=0 with err=1; dout=2 with err=0 (12 rounds to 2); dout=3 with err=1.
REQ-033 tin held high 40 cycles -> valid when wid_cnt=32, dout=3, err=1; a second start_rise during MEASURE is ignored.
REQ-034 rst_n low for 2 cycles in mid-pulse after wid_cnt=10 -> no valid, outputs 0, and a fresh 8-cycle pulse then decodes to dout=1.
REQ-035 With the macro defined, an 8-cycle pulse -> dout=1, and valid arrives 2 cycles later than without the macro.

Source files
------------

// File: rtl/time_decoder_if.sv
// Bundle of the frame strobe, pulse input and decoded-symbol outputs of time_decoder.
// valid is a one-cycle strobe with no ready: dout/err change only with valid and hold until the next one.
interface time_decoder_if;
    logic       start;
    logic       tin;
    logic [1:0] dout;
    logic       valid;
    logic       err;
    logic       busy;
    logic [1:0] state;

    modport master (
        output start, tin,
        input  dout, valid, err, busy, state
    );

    modport slave (
        input  start, tin,
        output dout, valid, err, busy, state
    );
endinterface

// File: rtl/time_decoder.sv
// Measures the high width of a time-encoded pulse after each start edge and decodes it to a 2-bit symbol.
// Optional macro TIME_DECODER_SYNC_EN inserts a 2-flop synchronizer on tin.
module time_decoder #(
    parameter int UNIT_CYCLES  = 8,
    parameter int WINDOW_UNITS = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    time_decoder_if.slave bus
);
    localparam int CW = $clog2(WINDOW_UNITS * UNIT_CYCLES + 1);
    localparam logic [CW-1:0] WIN_LAST = CW'(WINDOW_UNITS * UNIT_CYCLES - 1);
    localparam logic [CW-1:0] SAT      = CW'(4 * UNIT_CYCLES);
    localparam logic [CW-1:0] SAT_M1   = CW'(4 * UNIT_CYCLES - 1);
    localparam logic [CW-1:0] HALF     = CW'(UNIT_CYCLES / 2);
    localparam logic [CW-1:0] THR2     = CW'(2 * UNIT_CYCLES - UNIT_CYCLES / 2);
    localparam logic [CW-1:0] THR3     = CW'(3 * UNIT_CYCLES - UNIT_CYCLES / 2);
    localparam logic [CW-1:0] THR4     = CW'(4 * UNIT_CYCLES - UNIT_CYCLES / 2);
    localparam logic [CW-1:0] ONE      = CW'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t        state;
    logic          start_q;
    logic          start_rise;
    logic          tin_s;
    logic [CW-1:0] win_cnt;
    logic [CW-1:0] wid_cnt;
    logic [1:0]    dout_r;
    logic          err_r;
    logic          valid_r;
    logic [1:0]    dec_dout;
    logic          dec_err;

`ifdef TIME_DECODER_SYNC_EN
    logic tin_meta;
    logic tin_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tin_meta <= 1'b0;
            tin_sync <= 1'b0;
        end else begin
            tin_meta <= bus.tin;
            tin_sync <= tin_meta;
        end
    end

    assign tin_s = tin_sync;
`else
    assign tin_s = bus.tin;
`endif

    assign start_rise = bus.start & ~start_q;

    // Rounding to the nearest unit is done with thresholds offset by half a unit.
    always_comb begin
        dec_dout = 2'd1;
        dec_err  = 1'b0;
        if (wid_cnt < HALF) begin
            dec_dout = 2'd0;
            dec_err  = 1'b1;
        end else if (wid_cnt >= THR4) begin
            dec_dout = 2'd3;
            dec_err  = 1'b1;
        end else if (wid_cnt >= THR3) begin
            dec_dout = 2'd3;
        end else if (wid_cnt >= THR2) begin
            dec_dout = 2'd2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            start_q <= 1'b0;
            win_cnt <= '0;
            wid_cnt <= '0;
            dout_r  <= 2'd0;
            err_r   <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            start_q <= bus.start;
            valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_rise) begin
                        state   <= ARMED;
                        win_cnt <= '0;
                        wid_cnt <= '0;
                    end
                end
                ARMED: begin
                    win_cnt <= win_cnt + ONE;
                    // A pulse arriving on the expiry cycle still wins over the timeout.
                    if (tin_s) begin
                        state   <= MEASURE;
                        wid_cnt <= ONE;
                    end else if (win_cnt == WIN_LAST) begin
                        state   <= DONE;
                        valid_r <= 1'b1;
                        dout_r  <= 2'd0;
                        err_r   <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (tin_s) begin
                        if (wid_cnt >= SAT_M1) begin
                            wid_cnt <= SAT;
                            state   <= DONE;
                            valid_r <= 1'b1;
                            dout_r  <= 2'd3;
                            err_r   <= 1'b1;
                        end else begin
                            wid_cnt <= wid_cnt + ONE;
                        end
                    end else begin
                        state   <= DONE;
                        valid_r <= 1'b1;
                        dout_r  <= dec_dout;
                        err_r   <= dec_err;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.dout  = dout_r;
    assign bus.err   = err_r;
    assign bus.valid = valid_r;
    assign bus.busy  = (state != IDLE);
    assign bus.state = state;
endmodule

// File: tb/tb_time_decoder.sv
// Scoreboard bench for time_decoder: drivers push {cycle, err, dout} expectations, a negedge monitor pops them.
// Also covers reset values, window timeout, saturation, ignored restarts and reset mid-pulse.
module tb_time_decoder;
    localparam int U   = 8;
    localparam int WIN = 5;
    localparam int W   = 18;
`ifdef TIME_DECODER_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    logic [2:0] last_sym;
    logic [W-1:0] exp_q[$];

    time_decoder_if bus ();

    time_decoder #(
        .UNIT_CYCLES (U),
        .WINDOW_UNITS(WIN)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (got running, need finished)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [2:0] model_sym(input int w);
        int code;
        code = (w + U / 2) / U;
        if (code == 0)      return {1'b1, 2'd0};
        else if (code >= 4) return {1'b1, 2'd3};
        else                return {1'b0, 2'(code)};
    endfunction

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n && bus.valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("symbol", {14'd0, cyc[15:0], bus.err, bus.dout}, {14'd0, e});
            end
        end
    end

    task automatic drain_and_idle();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", exp_q.size(), 32'd0);
        repeat (3) @(negedge clk);
        check("busy_idle", {31'd0, bus.busy}, 32'd0);
        check("hold", {29'd0, bus.err, bus.dout}, {29'd0, last_sym});
    endtask

    // w = 0 means no pulse (window timeout); restart pulses start again mid-measure
    task automatic pulse(input int d, input int w, input bit restart);
        int n;
        int vcyc;
        logic [2:0] s;
        @(negedge clk);
        n = cyc;
        if (w == 0) begin
            vcyc = n + 1 + WIN * U;
            s = 3'b000;
        end else if (w >= 4 * U) begin
            vcyc = n + 1 + d + 4 * U + SYNC_LAT;
            s = {1'b1, 2'd3};
        end else begin
            vcyc = n + 2 + d + w + SYNC_LAT;
            s = model_sym(w);
        end
        exp_q.push_back({vcyc[15:0], s});
        last_sym = s;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (d) @(negedge clk);
        for (int i = 0; i < w; i++) begin
            bus.tin = 1'b1;
            bus.start = (restart && i == 10);
            @(negedge clk);
        end
        bus.tin = 1'b0;
        bus.start = 1'b0;
        drain_and_idle();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        last_sym = 3'b000;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.tin = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dout", {30'd0, bus.dout}, 32'd0);
        check("rst_valid", {31'd0, bus.valid}, 32'd0);
        check("rst_err", {31'd0, bus.err}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_state", {30'd0, bus.state}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        pulse(0, 16, 1'b0);
        pulse(0, 0, 1'b0);
        pulse(2, 3, 1'b0);
        pulse(1, 12, 1'b0);
        pulse(0, 28, 1'b0);
        pulse(0, 40, 1'b1);
        pulse(0, 4, 1'b0);
        pulse(0, 31, 1'b0);
        pulse(0, 32, 1'b0);
        // pulse first seen on the window-expiry cycle
        pulse(WIN * U - 1 - SYNC_LAT, 8, 1'b0);

        // reset in the middle of a pulse: symbol must be discarded
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.tin = 1'b1;
        repeat (10 + SYNC_LAT) @(negedge clk);
        check("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mrst_dout", {30'd0, bus.dout}, 32'd0);
        check("mrst_err", {31'd0, bus.err}, 32'd0);
        check("mrst_busy", {31'd0, bus.busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.tin = 1'b0;
        repeat (50) @(negedge clk);
        check("post_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("post_rst_dout", {30'd0, bus.dout}, 32'd0);
        last_sym = 3'b000;
        pulse(0, 8, 1'b0);

        for (int k = 0; k < 8; k++) begin
            pulse(int'($urandom_range(0, 3)), int'($urandom_range(1, 36)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
